// File: rtl/addsub_resp_checker.sv
// On-chip response checker for the W-bit adder/subtractor: counts beats and mismatches and captures the first failure.
// Optional build macro CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatch.
module addsub_resp_checker #(
    parameter int W       = 4,
    parameter int NUM_VEC = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    output logic             rdy,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             s,
    input  logic [W:0]       dut_sum,
    output logic             pass,
    output logic             fail,
    output logic             done,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ff_idx,
    output logic [W:0]       ff_exp,
    output logic [W:0]       ff_got,
    output logic             ff_vld
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

`ifdef CHECKER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    state_t     state;
    logic [W:0] exp_sum;
    logic       accept;
    logic       mismatch;

    always_comb begin
        exp_sum = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    end

    // start has priority, so a beat offered alongside it is dropped
    assign accept   = vld & rdy & ~start;
    assign mismatch = (dut_sum != exp_sum);
    assign rdy      = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pass    <= 1'b0;
            fail    <= 1'b0;
            vec_cnt <= '0;
            err_cnt <= '0;
            ff_idx  <= '0;
            ff_exp  <= '0;
            ff_got  <= '0;
            ff_vld  <= 1'b0;
        end else begin
            pass <= 1'b0;
            fail <= 1'b0;
            if (start) begin
                state   <= RUN;
                vec_cnt <= '0;
                err_cnt <= '0;
                ff_idx  <= '0;
                ff_exp  <= '0;
                ff_got  <= '0;
                ff_vld  <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        if (accept) begin
                            pass    <= ~mismatch;
                            fail    <= mismatch;
                            vec_cnt <= vec_cnt + CNT_W'(1);
                            if (mismatch) begin
                                if (err_cnt != ERR_MAX)
                                    err_cnt <= err_cnt + CNT_W'(1);
                                if (!ff_vld) begin
                                    ff_idx <= vec_cnt;
                                    ff_exp <= exp_sum;
                                    ff_got <= dut_sum;
                                    ff_vld <= 1'b1;
                                end
                            end
                            if (vec_cnt == LAST_IDX || (mismatch && STOP_ON_FAIL))
                                state <= DONE;
                        end
                    end
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_addsub_resp_checker.sv
// Randomized self-checking bench for addsub_resp_checker against a beat-level reference model.
// Honours CHECKER_STOP_ON_FAIL_EN in the model when the design is built with it.
module tb_addsub_resp_checker;

    localparam int W       = 4;
    localparam int NUM_VEC = 16;
    localparam int CNT_W   = 8;
    localparam int ERR_MAX = (1 << CNT_W) - 1;

`ifdef CHECKER_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             vld;
    logic             rdy;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             s;
    logic [W:0]       dut_sum;
    logic             pass;
    logic             fail;
    logic             done;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] ff_idx;
    logic [W:0]       ff_exp;
    logic [W:0]       ff_got;
    logic             ff_vld;

    addsub_resp_checker #(.W(W), .NUM_VEC(NUM_VEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld), .rdy(rdy),
        .a(a), .b(b), .s(s), .dut_sum(dut_sum),
        .pass(pass), .fail(fail), .done(done),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt),
        .ff_idx(ff_idx), .ff_exp(ff_exp), .ff_got(ff_got), .ff_vld(ff_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: what a run of the checker should have recorded so far
    bit modelRun;
    bit modelDone;
    int modelVec;
    int modelErr;
    bit modelFfVld;
    int modelFfIdx;
    int modelFfExp;
    int modelFfGot;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int refSum(input int ra, input int rb, input bit rs);
        int r;
        r = rs ? (ra - rb) : (ra + rb);
        return ((r % 32) + 32) % 32;
    endfunction

    task automatic clearModel();
        modelVec   = 0;
        modelErr   = 0;
        modelFfVld = 0;
        modelFfIdx = 0;
        modelFfExp = 0;
        modelFfGot = 0;
    endtask

    task automatic checkState(input string tag, input bit expPass, input bit expFail);
        checkOutput({tag, "_pass"},   32'(pass),    32'(expPass));
        checkOutput({tag, "_fail"},   32'(fail),    32'(expFail));
        checkOutput({tag, "_vec"},    32'(vec_cnt), modelVec);
        checkOutput({tag, "_err"},    32'(err_cnt), modelErr);
        checkOutput({tag, "_done"},   32'(done),    32'(modelDone));
        checkOutput({tag, "_rdy"},    32'(rdy),     32'(modelRun));
        checkOutput({tag, "_ffvld"},  32'(ff_vld),  32'(modelFfVld));
        checkOutput({tag, "_ffidx"},  32'(ff_idx),  modelFfIdx);
        checkOutput({tag, "_ffexp"},  32'(ff_exp),  modelFfExp);
        checkOutput({tag, "_ffgot"},  32'(ff_got),  modelFfGot);
    endtask

    // Called just after a falling edge; returns just after a later falling edge
    task automatic startRun();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clearModel();
        modelRun  = 1;
        modelDone = 0;
        checkState("start", 0, 0);
    endtask

    task automatic applyStimulus(input int ta, input int tb, input bit ts, input int tsum, input int idle);
        bit accepted;
        bit bad;
        int e;
        for (int i = 0; i < idle; i++) begin
            vld = 1'b0;
            a   = 4'($urandom);
            b   = 4'($urandom);
            @(negedge clk);
            checkState("idle", 0, 0);
        end
        accepted = modelRun;
        a       = 4'(ta);
        b       = 4'(tb);
        s       = ts;
        dut_sum = 5'(tsum);
        vld     = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        bad = 0;
        if (accepted) begin
            e   = refSum(ta, tb, ts);
            bad = (tsum != e);
            if (bad) begin
                if (modelErr < ERR_MAX) modelErr++;
                if (!modelFfVld) begin
                    modelFfVld = 1;
                    modelFfIdx = modelVec;
                    modelFfExp = e;
                    modelFfGot = tsum;
                end
            end
            modelVec++;
            if (modelVec == NUM_VEC || (bad && STOP_ON_FAIL)) begin
                modelRun  = 0;
                modelDone = 1;
            end
        end
        checkState("beat", accepted && !bad, accepted && bad);
    endtask

    task automatic randomBeat(input int errPct, input int maxIdle);
        int ra, rb, e, got;
        bit rs;
        ra  = $urandom_range(15);
        rb  = $urandom_range(15);
        rs  = 1'($urandom);
        e   = refSum(ra, rb, rs);
        got = e;
        if ($urandom_range(99) < errPct) got = e ^ $urandom_range(1, 31);
        applyStimulus(ra, rb, rs, got, $urandom_range(maxIdle));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        vld     = 1'b0;
        a       = '0;
        b       = '0;
        s       = 1'b0;
        dut_sum = '0;
        modelRun  = 0;
        modelDone = 0;
        clearModel();

        repeat (2) @(negedge clk);
        checkState("reset", 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkState("idle_after_reset", 0, 0);

        $display("[TB] all-correct run");
        startRun();
        for (int i = 0; i < NUM_VEC; i++)
            applyStimulus(0, i, 0, i, 0);
        checkOutput("run1_done", 32'(done), 32'(1));
        applyStimulus(3, 3, 0, 6, 0);

        $display("[TB] single mismatch at beat 3");
        startRun();
        for (int i = 0; i < NUM_VEC && modelRun; i++) begin
            if (i == 3) applyStimulus(15, 7, 1, 9, 0);
            else        randomBeat(0, 0);
        end
        checkOutput("run2_ffexp", 32'(ff_exp), 32'(8));
        checkOutput("run2_ffidx", 32'(ff_idx), 32'(3));

        $display("[TB] mismatches at beats 2 and 5");
        startRun();
        for (int i = 0; i < NUM_VEC && modelRun; i++) begin
            if (i == 2)      applyStimulus(5, 9, 0, 15, 1);
            else if (i == 5) applyStimulus(2, 6, 1, 3, 2);
            else             randomBeat(0, 1);
        end

        $display("[TB] random runs with gaps");
        for (int r = 0; r < 3; r++) begin
            startRun();
            for (int i = 0; i < 40 && modelRun; i++)
                randomBeat(25, 3);
            checkOutput("rand_end_done", 32'(done), 32'(1));
        end

        $display("[TB] start coincident with a beat");
        startRun();
        for (int i = 0; i < 3 && modelRun; i++) randomBeat(50, 1);
        start   = 1'b1;
        vld     = 1'b1;
        a       = 4'd1;
        b       = 4'd1;
        s       = 1'b0;
        dut_sum = 5'd7;
        @(negedge clk);
        start = 1'b0;
        vld   = 1'b0;
        clearModel();
        modelRun  = 1;
        modelDone = 0;
        checkState("start_vld", 0, 0);
        for (int i = 0; i < 40 && modelRun; i++) randomBeat(20, 3);

        $display("[TB] reset mid-run");
        startRun();
        for (int i = 0; i < 5; i++) randomBeat(30, 0);
        #2 rst_n = 1'b0;
        #1;
        clearModel();
        modelRun  = 0;
        modelDone = 0;
        checkState("async_reset", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        startRun();
        for (int i = 0; i < 40 && modelRun; i++) randomBeat(0, 2);
        checkOutput("after_reset_err", 32'(err_cnt), 32'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
